// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between the master and apb_mem_slave.
// PSTRB exists only when APB_SLV_PSTRB_EN is defined.
interface apb_mem_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  PSTRB;
`endif
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
`ifdef APB_SLV_PSTRB_EN
    output PSTRB,
`endif
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
`ifdef APB_SLV_PSTRB_EN
    input  PSTRB,
`endif
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB completer backed by a DEPTH x 32-bit word memory with WAIT_CYCLES stalls per access.
// Define APB_SLV_PSTRB_EN to enable byte-lane write strobes (PSTRB).
module apb_mem_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_mem_slave_if.slave apb
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_err;
  logic          r_write;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic          w_err;
  logic          w_pready;
  logic          w_commit;

  // Range check on the offset: once PADDR >= BASE_ADDR the subtraction cannot wrap.
  assign w_off = apb.PADDR - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];

`ifdef APB_SLV_PSTRB_EN
  assign w_be  = apb.PSTRB;
  assign w_err = (w_off[1:0] != 2'b00) || (apb.PADDR < BASE_ADDR) ||
                 (w_off >= 32'(DEPTH * 4)) || (!apb.PWRITE && (apb.PSTRB != 4'b0000));
`else
  assign w_be  = 4'hF;
  assign w_err = (w_off[1:0] != 2'b00) || (apb.PADDR < BASE_ADDR) ||
                 (w_off >= 32'(DEPTH * 4));
`endif

  assign w_pready = (r_state == ACCESS) && apb.PSEL && apb.PENABLE && (r_cnt == 4'd0);
  assign w_commit = w_pready && r_write && !r_err && !PRESET;

  assign apb.PREADY  = w_pready;
  assign apb.PSLVERR = w_pready && r_err;
  assign apb.PRDATA  = r_rdata;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            r_state <= ACCESS;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_err   <= w_err;
            r_write <= apb.PWRITE;
            r_idx   <= w_idx;
            r_wdata <= apb.PWDATA;
            r_be    <= w_be;
            if (!apb.PWRITE) begin
              r_rdata <= w_err ? 32'h0 : r_mem[w_idx];
            end
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            r_state <= IDLE;
          end else if (apb.PENABLE) begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory is deliberately outside reset so it maps onto block RAM with byte enables.
  always_ff @(posedge PCLK) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule
